// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight RAM writer and reader: FSM encoding and
// address-width derivation.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } wl_state_e;

  // ceil(log2(n)) but never below 1, so a single-entry dimension still gets
  // a legal one-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_col_packer.sv
// Column buffer: collects one weight per lane and presents them as a packed
// column word. Lane k holds row k of the column being assembled.
module weight_col_packer
  import weight_loader_pkg::*;
#(
  parameter int NROW     = 16,
  parameter int BITWIDTH = 18,
  localparam int LANE_W  = clog2_min1(NROW)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               we,
  input  logic [LANE_W-1:0]                  lane,
  input  logic [BITWIDTH-1:0]                din,
  output logic [NROW-1:0][BITWIDTH-1:0]      word
);

  for (genvar k = 0; k < NROW; k++) begin : g_lane
    logic [BITWIDTH-1:0] q;

    // Capture din when this lane is the addressed one.
    always_ff @(posedge clk) begin
      if (reset)                               q <= '0;
      else if (we && (lane == LANE_W'(k)))     q <= din;
    end

    assign word[k] = q;
  end

endmodule

// File: rtl/weight_loader.sv
// Streams a column-major weight matrix in one word at a time and writes it
// into the weight RAM one packed column per write strobe.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int NROW     = 16,
  parameter int NCOL     = 16,
  parameter int BITWIDTH = 18,
  localparam int ADDR_BITWIDTH = clog2_min1(NCOL),
  localparam int ROW_BITWIDTH  = clog2_min1(NROW)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BITWIDTH-1:0]          dataIn,
  input  logic                         inValid,
  output logic                         inReady,
  output logic                         wrEn,
  output logic [ADDR_BITWIDTH-1:0]     wrAddr,
  output logic [BITWIDTH*NROW-1:0]     wrData,
  output logic                         done
);

  localparam logic [ROW_BITWIDTH-1:0]  ROW_LAST = ROW_BITWIDTH'(NROW - 1);
  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST = ADDR_BITWIDTH'(NCOL - 1);

  wl_state_e                     state_q, state_d;
  logic [ROW_BITWIDTH-1:0]       row_cnt;
  logic [ADDR_BITWIDTH-1:0]      col_cnt;
  logic                          xfer, row_last, col_last, go;
  logic [NROW-1:0][BITWIDTH-1:0] col_buf, col_word;

  logic                          wr_en_q;
  logic [ADDR_BITWIDTH-1:0]      wr_addr_q;
  logic [NROW-1:0][BITWIDTH-1:0] wr_data_q;

  assign inReady  = (state_q == LOAD);
  assign xfer     = inReady && inValid;
  assign row_last = (row_cnt == ROW_LAST);
  assign col_last = (col_cnt == COL_LAST);
  assign go       = start && ((state_q == IDLE) || (state_q == DONE));

  weight_col_packer #(
    .NROW     (NROW),
    .BITWIDTH (BITWIDTH)
  ) u_packer (
    .clk   (clk),
    .reset (reset),
    .we    (xfer),
    .lane  (row_cnt),
    .din   (dataIn),
    .word  (col_buf)
  );

  // The column is registered on the same edge that accepts its last word,
  // so that word is merged straight from dataIn into the top lane.
  always_comb begin
    col_word           = col_buf;
    col_word[NROW-1]   = dataIn;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (xfer && row_last) state_d = WRITE;
      WRITE:   state_d = col_last ? DONE : LOAD;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Row/column counters; neither wraps past its last index.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (go) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (xfer) begin
      row_cnt <= row_last ? '0 : row_cnt + 1'b1;
    end else if ((state_q == WRITE) && !col_last) begin
      col_cnt <= col_cnt + 1'b1;
    end
  end

  // RAM write port: one-cycle strobe; address/data hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= xfer && row_last;
      if (xfer && row_last) begin
        wr_addr_q <= col_cnt;
        wr_data_q <= col_word;
      end
    end
  end

  assign wrEn   = wr_en_q;
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;
  assign done   = (state_q == DONE);

endmodule
